ram_slot_arbiter: RTL

RAM_SLOT_ARBITER -- requirements
Module: ram_slot_arbiter

---
 rtl/ram_slot_arbiter_pkg.sv | 15 +
 rtl/ram_slot_arbiter_slot_phase_counter.sv | 32 +++
 rtl/ram_slot_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_slot_arbiter_pkg.sv
// Shared slot-phase definitions for the RAM slot arbiter.
package ram_slot_arbiter_pkg;

  // One 8-phase frame, phase 7 is marked by ce2H.
  typedef logic [2:0] phase_t;

  localparam phase_t PHASE_LAST       = 3'd7;
  localparam phase_t VID_SLOT_DEFAULT = 3'd0;
  localparam phase_t CPU_SLOT_DEFAULT = 3'd4;

  function automatic phase_t phase_next(input phase_t p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/ram_slot_arbiter_slot_phase_counter.sv
// Free-running 3-bit slot phase, re-aligned by ce2H, plus the phase_ok flag
// that gates all RAM traffic until the first alignment strobe is seen.
module ram_slot_arbiter_slot_phase_counter
  import ram_slot_arbiter_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset_n,
  input  logic   i_ce2h,
  output phase_t o_phase,
  output logic   o_phase_ok
);

  phase_t r_phase;
  logic   r_phase_ok;

  // Phase 0 always follows the ce2H cycle, even when it arrives off-phase.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_phase    <= '0;
      r_phase_ok <= 1'b0;
    end else if (i_ce2h) begin
      r_phase    <= '0;
      r_phase_ok <= 1'b1;
    end else begin
      r_phase    <= phase_next(r_phase);
    end
  end

  assign o_phase    = r_phase;
  assign o_phase_ok = r_phase_ok;

endmodule

// File: rtl/ram_slot_arbiter.sv
// Fixed-slot arbiter sharing one synchronous RAM between a video fetcher and
// a CPU port. Each owner gets one dedicated phase per 8-clock frame, so the
// two never contend; the RAM-side address/strobe are driven in the slot cycle
// and the read data is forwarded to the owner in the following cycle.
module ram_slot_arbiter
  import ram_slot_arbiter_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int VID_SLOT = int'(VID_SLOT_DEFAULT),
  parameter int CPU_SLOT = int'(CPU_SLOT_DEFAULT)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce2h,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_din,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_dout,
  input  logic          i_vid_req,
  input  logic [AW-1:0] i_vid_addr,
  output logic          o_vid_valid,
  output logic [DW-1:0] o_vid_data,
  output logic          o_vid_overrun,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout
);

  localparam phase_t VID_PH = phase_t'(VID_SLOT);
  localparam phase_t CPU_PH = phase_t'(CPU_SLOT);

  phase_t        w_phase;
  logic          w_phase_ok;
  logic          w_vid_issue;
  logic          w_cpu_issue;

  logic          r_vid_pend;
  logic [AW-1:0] r_vid_addr;
  logic          r_vid_overrun;
  logic          r_vid_valid;
  logic [DW-1:0] r_vid_data;
  logic          r_cpu_ack;
  logic          r_cpu_rd;
  logic [DW-1:0] r_cpu_dout;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;

  ram_slot_arbiter_slot_phase_counter u_phase (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ce2h     (i_ce2h),
    .o_phase    (w_phase),
    .o_phase_ok (w_phase_ok)
  );

  // The ack guard keeps a request whose ack is still on the wire (possible
  // only after an off-phase re-alignment) from being issued twice.
  assign w_vid_issue = w_phase_ok && (w_phase == VID_PH) && r_vid_pend;
  assign w_cpu_issue = w_phase_ok && (w_phase == CPU_PH) && i_cpu_req && !r_cpu_ack;

  // RAM side is combinational in the slot so a request raised exactly at its
  // slot is served that cycle; outside slots the last address/data are held.
  assign o_ram_addr = w_vid_issue ? r_vid_addr :
                      w_cpu_issue ? i_cpu_addr : r_ram_addr;
  assign o_ram_we   = w_cpu_issue && i_cpu_we;
  assign o_ram_din  = w_cpu_issue ? i_cpu_din : r_ram_din;

  // Read data arrives one cycle after the slot; pass it through during the
  // completion pulse and keep it afterwards.
  assign o_cpu_ack     = r_cpu_ack;
  assign o_cpu_dout    = (r_cpu_ack && r_cpu_rd) ? i_ram_dout : r_cpu_dout;
  assign o_vid_valid   = r_vid_valid;
  assign o_vid_data    = r_vid_valid ? i_ram_dout : r_vid_data;
  assign o_vid_overrun = r_vid_overrun;

  // Slot bookkeeping: pending video latch, completion pulses, held RAM bus.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vid_pend    <= 1'b0;
      r_vid_addr    <= '0;
      r_vid_overrun <= 1'b0;
      r_vid_valid   <= 1'b0;
      r_vid_data    <= '0;
      r_cpu_ack     <= 1'b0;
      r_cpu_rd      <= 1'b0;
      r_cpu_dout    <= '0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
    end else begin
      r_ram_addr  <= o_ram_addr;
      r_ram_din   <= o_ram_din;
      r_cpu_ack   <= w_cpu_issue;
      r_cpu_rd    <= w_cpu_issue && !i_cpu_we;
      r_vid_valid <= w_vid_issue;

      if (r_cpu_ack && r_cpu_rd)
        r_cpu_dout <= i_ram_dout;
      if (r_vid_valid)
        r_vid_data <= i_ram_dout;

      // A new request may reuse the latch in the very cycle it issues;
      // otherwise a second request while pending is dropped and flagged.
      if (i_vid_req) begin
        if (r_vid_pend && !w_vid_issue) begin
          r_vid_overrun <= 1'b1;
        end else begin
          r_vid_pend <= 1'b1;
          r_vid_addr <= i_vid_addr;
        end
      end else if (w_vid_issue) begin
        r_vid_pend <= 1'b0;
      end
    end
  end

endmodule
